// File: rtl/insn_encode_loader_pkg.sv
// X9 ISA encoding constants and loader types shared by the loader RTL and its benches.
package insn_encode_loader_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
        OP_LB   = 5'd8,  OP_SB   = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11,
        OP_JR   = 5'd12, OP_SLT  = 5'd13, OP_NOT  = 5'd14, OP_RXOR = 5'd15,
        OP_MOVR = 5'd16, OP_MOVI = 5'd17
    } mnem_e;

    localparam logic [1:0] FMT_MOVR = 2'b10;
    localparam logic [1:0] FMT_MOVI = 2'b11;

    typedef enum logic [1:0] {CMD_EMIT, CMD_ORG, CMD_END, CMD_RSVD} ldr_cmd_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_OVERFLOW, ERR_VERIFY} err_code_e;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CHECK, ST_DONE, ST_ERROR} state_e;

endpackage

// File: rtl/insn_encode_loader_if.sv
// Loader request channel, instruction-memory port and status, bundled for the loader.
interface insn_encode_loader_if #(parameter int AW = 8);
    import insn_encode_loader_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_cmd;
    logic [4:0]         req_op;
    logic [3:0]         req_ra;
    logic [2:0]         req_rb;
    logic [6:0]         req_imm;
    logic [AW-1:0]      req_addr;
    logic               im_we;
    logic               im_re;
    logic [AW-1:0]      im_addr;
    logic [INSTR_W-1:0] im_wdata;
    logic [INSTR_W-1:0] im_rdata;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    logic [AW:0]        count;

    modport master (
        output req_valid, req_cmd, req_op, req_ra, req_rb, req_imm, req_addr, im_rdata,
        input  req_ready, im_we, im_re, im_addr, im_wdata, busy, done, err, err_code, count
    );

    modport slave (
        input  req_valid, req_cmd, req_op, req_ra, req_rb, req_imm, req_addr, im_rdata,
        output req_ready, im_we, im_re, im_addr, im_wdata, busy, done, err, err_code, count
    );

endinterface

// File: rtl/insn_encode_loader_packer.sv
// Combinational X9 packer: mnemonic + operand fields -> 9-bit machine word and legality.
module insn_encode_loader_packer
    import insn_encode_loader_pkg::*;
(
    input  logic [4:0]         i_op,
    input  logic [3:0]         i_ra,
    input  logic [2:0]         i_rb,
    input  logic [6:0]         i_imm,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_legal
);

    // R-type words keep op[4]=0 in the MSB, which separates them from the 2'b1x formats.
    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        if (i_op <= OP_RXOR)       o_word = {i_op, i_ra};
        else if (i_op == OP_MOVR)  o_word = {FMT_MOVR, i_ra, i_rb};
        else if (i_op == OP_MOVI)  o_word = {FMT_MOVI, i_imm};
        else                       o_legal = 1'b0;
    end

endmodule

// File: rtl/insn_encode_loader.sv
// Sequential X9 program loader: packs requests, writes them to instruction memory, optionally verifies.
module insn_encode_loader
    import insn_encode_loader_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int VERIFY = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    insn_encode_loader_if.slave bus
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_e             r_state, w_next;
    logic [AW:0]        r_pc, r_count;
    logic [INSTR_W-1:0] r_word, w_word;
    logic               r_done, r_err;
    err_code_e          r_err_code, w_err_code;
    logic               w_legal, w_latch, w_org, w_commit, w_set_err, w_set_done;

    insn_encode_loader_packer u_packer (
        .i_op   (bus.req_op),
        .i_ra   (bus.req_ra),
        .i_rb   (bus.req_rb),
        .i_imm  (bus.req_imm),
        .o_word (w_word),
        .o_legal(w_legal)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_next;
            if (w_latch) r_word <= w_word;
            if (w_org)   r_pc   <= {1'b0, bus.req_addr};
            if (w_commit) begin
                r_pc <= r_pc + LP_ONE;
                if (r_count < LP_DEPTH) r_count <= r_count + LP_ONE;
            end
            if (w_set_done) r_done <= 1'b1;
            if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    // Strobes decode from state only, so an async reset removes them without a clock.
    always_comb begin
        w_next        = r_state;
        w_latch       = 1'b0;
        w_org         = 1'b0;
        w_commit      = 1'b0;
        w_set_err     = 1'b0;
        w_set_done    = 1'b0;
        w_err_code    = ERR_NONE;
        bus.req_ready = 1'b0;
        bus.im_we     = 1'b0;
        bus.im_re     = 1'b0;
        bus.im_addr   = '0;
        bus.im_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    case (bus.req_cmd)
                        CMD_EMIT: begin
                            if (!w_legal) begin
                                w_set_err  = 1'b1;
                                w_err_code = ERR_ILLEGAL;
                                w_next     = ST_ERROR;
                            end else if (r_pc >= LP_DEPTH) begin
                                w_set_err  = 1'b1;
                                w_err_code = ERR_OVERFLOW;
                                w_next     = ST_ERROR;
                            end else begin
                                w_latch = 1'b1;
                                w_next  = ST_WRITE;
                            end
                        end
                        CMD_ORG: w_org = 1'b1;
                        CMD_END: begin
                            w_set_done = 1'b1;
                            w_next     = ST_DONE;
                        end
                        default: begin
                            w_set_err  = 1'b1;
                            w_err_code = ERR_ILLEGAL;
                            w_next     = ST_ERROR;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                bus.im_we    = 1'b1;
                bus.im_addr  = r_pc[AW-1:0];
                bus.im_wdata = r_word;
                if (VERIFY != 0) begin
                    w_next = ST_READ;
                end else begin
                    w_commit = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            ST_READ: begin
                bus.im_re   = 1'b1;
                bus.im_addr = r_pc[AW-1:0];
                w_next      = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.im_rdata == r_word) begin
                    w_commit = 1'b1;
                    w_next   = ST_IDLE;
                end else begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_VERIFY;
                    w_next     = ST_ERROR;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy     = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_CHECK);
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
    assign bus.count    = r_count;

endmodule

// File: tb/tb_insn_encode_loader.sv
// Directed bench: verify-mode loader (AW=8, DEPTH=256) and write-only loader (AW=4, DEPTH=12).
module tb_insn_encode_loader;
    import insn_encode_loader_pkg::*;

    typedef struct {
        logic [4:0] op;
        logic [3:0] ra;
        logic [2:0] rb;
        logic [6:0] imm;
        logic [8:0] word;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    insn_encode_loader_if #(.AW(8)) a ();
    insn_encode_loader_if #(.AW(4)) b ();

    insn_encode_loader #(.AW(8), .DEPTH(256), .VERIFY(1)) u_dut_v (.Clk(Clk), .Reset_n(Reset_n), .bus(a));
    insn_encode_loader #(.AW(4), .DEPTH(12),  .VERIFY(0)) u_dut_w (.Clk(Clk), .Reset_n(Reset_n), .bus(b));

    // Shared stimulus; sel picks which loader sees req_valid and which outputs are observed.
    logic       sel = 1'b0;
    logic       s_valid = 1'b0;
    logic [1:0] s_cmd = '0;
    logic [4:0] s_op = '0;
    logic [3:0] s_ra = '0;
    logic [2:0] s_rb = '0;
    logic [6:0] s_imm = '0;
    logic [7:0] s_addr = '0;
    logic       corrupt = 1'b0;

    assign a.req_valid = s_valid & ~sel;
    assign a.req_cmd = s_cmd;  assign a.req_op = s_op;  assign a.req_ra = s_ra;
    assign a.req_rb = s_rb;    assign a.req_imm = s_imm; assign a.req_addr = s_addr;
    assign b.req_valid = s_valid & sel;
    assign b.req_cmd = s_cmd;  assign b.req_op = s_op;  assign b.req_ra = s_ra;
    assign b.req_rb = s_rb;    assign b.req_imm = s_imm; assign b.req_addr = s_addr[3:0];
    assign b.im_rdata = '0;

    logic       m_ready, m_we, m_re, m_busy, m_done, m_err;
    logic [7:0] m_addr;
    logic [8:0] m_wdata, m_count;
    logic [1:0] m_code;
    assign m_ready = sel ? b.req_ready : a.req_ready;
    assign m_we    = sel ? b.im_we     : a.im_we;
    assign m_re    = sel ? b.im_re     : a.im_re;
    assign m_busy  = sel ? b.busy      : a.busy;
    assign m_done  = sel ? b.done      : a.done;
    assign m_err   = sel ? b.err       : a.err;
    assign m_code  = sel ? b.err_code  : a.err_code;
    assign m_addr  = sel ? {4'd0, b.im_addr} : a.im_addr;
    assign m_wdata = sel ? b.im_wdata  : a.im_wdata;
    assign m_count = sel ? {4'd0, b.count} : a.count;

    // Instruction memory for the verify loader; bit 0 of address 4 can be corrupted on read.
    logic [8:0] mem [256];
    int we_cnt = 0;
    always @(posedge Clk) begin
        if (a.im_we) mem[a.im_addr] <= a.im_wdata;
        if (a.im_re) a.im_rdata <= mem[a.im_addr] ^ {8'd0, corrupt && (a.im_addr == 8'd4)};
        if (m_we) we_cnt <= we_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Returns on the negedge just after the handshake edge.
    task automatic send(input logic [1:0] cmd, input logic [4:0] op, input logic [3:0] ra,
                        input logic [2:0] rb, input logic [6:0] imm, input logic [7:0] addr);
        int n = 0;
        @(negedge Clk);
        while (!m_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!m_ready) begin
            chk("req_ready_wait", {31'd0, m_ready}, 32'd1);
            return;
        end
        s_cmd = cmd; s_op = op; s_ra = ra; s_rb = rb; s_imm = imm; s_addr = addr;
        s_valid = 1'b1;
        @(negedge Clk);
        s_valid = 1'b0;
    endtask

    task automatic emit_chk(input vec_t v, input logic [7:0] exp_addr);
        int n = 0;
        send(CMD_EMIT, v.op, v.ra, v.rb, v.imm, 8'd0);
        chk("write_we", {31'd0, m_we}, 32'd1);
        chk("write_addr", {24'd0, m_addr}, {24'd0, exp_addr});
        chk("write_word", {23'd0, m_wdata}, {23'd0, v.word});
        if (!sel) begin
            @(negedge Clk);
            n = 1;
            chk("read_re", {31'd0, m_re}, 32'd1);
            chk("read_addr", {24'd0, m_addr}, {24'd0, exp_addr});
        end
        while (!m_ready && n < 10) begin
            @(negedge Clk);
            n++;
        end
        chk("emit_latency", n, sel ? 32'd1 : 32'd3);
    endtask

    vec_t tab [7];
    vec_t v_sub;
    int   w0;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{5'd0,  4'd3, 3'd5, 7'h11, 9'h003};
        tab[1] = '{5'd17, 4'hF, 3'd7, 7'h55, 9'h1D5};
        tab[2] = '{5'd16, 4'd5, 3'd2, 7'h7F, 9'h12A};
        tab[3] = '{5'd15, 4'hF, 3'd0, 7'h00, 9'h0FF};
        tab[4] = '{5'd16, 4'hF, 3'd7, 7'h00, 9'h17F};
        tab[5] = '{5'd17, 4'd5, 3'd0, 7'h00, 9'h180};
        tab[6] = '{5'd14, 4'd0, 3'd7, 7'h7F, 9'h0E0};
        v_sub  = '{5'd1,  4'd1, 3'd0, 7'h00, 9'h011};

        // Reset state
        do_reset();
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_we", {31'd0, m_we}, 32'd0);
        chk("rst_re", {31'd0, m_re}, 32'd0);
        chk("rst_addr", {24'd0, m_addr}, 32'd0);
        chk("rst_wdata", {23'd0, m_wdata}, 32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_done", {31'd0, m_done}, 32'd0);
        chk("rst_err", {31'd0, m_err}, 32'd0);
        chk("rst_code", {30'd0, m_code}, 32'd0);
        chk("rst_count", {23'd0, m_count}, 32'd0);

        // Table of packings, written sequentially with read-back
        for (int i = 0; i < 7; i++) begin
            emit_chk(tab[i], 8'(i));
            chk("count_step", {23'd0, m_count}, i + 1);
        end
        for (int i = 0; i < 7; i++) chk("mem_word", {23'd0, mem[i]}, {23'd0, tab[i].word});
        send(CMD_END, 5'd0, 4'd0, 3'd0, 7'd0, 8'd0);
        chk("end_done", {31'd0, m_done}, 32'd1);
        chk("end_ready", {31'd0, m_ready}, 32'd0);
        chk("end_busy", {31'd0, m_busy}, 32'd0);
        chk("end_count", {23'd0, m_count}, 32'd7);
        w0 = we_cnt;
        s_cmd = CMD_EMIT; s_op = 5'd0; s_valid = 1'b1;
        repeat (3) @(negedge Clk);
        chk("done_ready_held", {31'd0, m_ready}, 32'd0);
        chk("done_no_write", we_cnt, w0);
        s_valid = 1'b0;

        // ORG to the last word, ORG back from pc==DEPTH, then overflow
        do_reset();
        chk("rst2_count", {23'd0, m_count}, 32'd0);
        send(CMD_ORG, 5'd0, 4'd0, 3'd0, 7'd0, 8'hFF);
        chk("org_count", {23'd0, m_count}, 32'd0);
        emit_chk(v_sub, 8'hFF);
        send(CMD_ORG, 5'd0, 4'd0, 3'd0, 7'd0, 8'h10);
        emit_chk(v_sub, 8'h10);
        send(CMD_ORG, 5'd0, 4'd0, 3'd0, 7'd0, 8'hFF);
        emit_chk(v_sub, 8'hFF);
        chk("org_writes_count", {23'd0, m_count}, 32'd3);
        w0 = we_cnt;
        send(CMD_EMIT, 5'd8, 4'd0, 3'd0, 7'd0, 8'd0);
        chk("ovf_err", {31'd0, m_err}, 32'd1);
        chk("ovf_code", {30'd0, m_code}, 32'd2);
        chk("ovf_ready", {31'd0, m_ready}, 32'd0);
        chk("ovf_no_write", we_cnt, w0);
        chk("ovf_count", {23'd0, m_count}, 32'd3);

        // Illegal mnemonic, then requests ignored
        do_reset();
        w0 = we_cnt;
        send(CMD_EMIT, 5'd20, 4'd1, 3'd0, 7'd0, 8'd0);
        chk("ill_err", {31'd0, m_err}, 32'd1);
        chk("ill_code", {30'd0, m_code}, 32'd1);
        s_cmd = CMD_EMIT; s_op = 5'd0; s_valid = 1'b1;
        repeat (3) @(negedge Clk);
        chk("ill_ready_held", {31'd0, m_ready}, 32'd0);
        chk("ill_no_write", we_cnt, w0);
        s_valid = 1'b0;

        // Reserved command
        do_reset();
        send(CMD_RSVD, 5'd0, 4'd0, 3'd0, 7'd0, 8'd0);
        chk("rsvd_err", {31'd0, m_err}, 32'd1);
        chk("rsvd_code", {30'd0, m_code}, 32'd1);
        chk("rsvd_done", {31'd0, m_done}, 32'd0);

        // Read-back mismatch at address 4
        do_reset();
        corrupt = 1'b1;
        for (int i = 0; i < 4; i++) emit_chk(tab[i], 8'(i));
        send(CMD_EMIT, tab[4].op, tab[4].ra, tab[4].rb, tab[4].imm, 8'd0);
        chk("vfy_we", {31'd0, m_we}, 32'd1);
        chk("vfy_addr", {24'd0, m_addr}, 32'd4);
        repeat (3) @(negedge Clk);
        chk("vfy_err", {31'd0, m_err}, 32'd1);
        chk("vfy_code", {30'd0, m_code}, 32'd3);
        chk("vfy_count", {23'd0, m_count}, 32'd4);
        chk("vfy_ready", {31'd0, m_ready}, 32'd0);
        corrupt = 1'b0;

        // Reset dropped in the middle of a write
        do_reset();
        emit_chk(tab[0], 8'd0);
        send(CMD_EMIT, 5'd4, 4'd2, 3'd0, 7'd0, 8'd0);
        chk("mid_we", {31'd0, m_we}, 32'd1);
        chk("mid_addr", {24'd0, m_addr}, 32'd1);
        #1 Reset_n = 1'b0;
        #1 chk("async_we_drop", {31'd0, m_we}, 32'd0);
        chk("async_busy_drop", {31'd0, m_busy}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_ready", {31'd0, m_ready}, 32'd1);
        chk("post_rst_count", {23'd0, m_count}, 32'd0);
        emit_chk(tab[0], 8'd0);

        // Write-only loader: 2-cycle spacing, DEPTH < 2**AW, count saturation
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) emit_chk(tab[i % 7], 8'(i));
        chk("wo_count_full", {23'd0, m_count}, 32'd12);
        send(CMD_ORG, 5'd0, 4'd0, 3'd0, 7'd0, 8'd0);
        emit_chk(tab[0], 8'd0);
        chk("wo_count_sat", {23'd0, m_count}, 32'd12);
        send(CMD_ORG, 5'd0, 4'd0, 3'd0, 7'd0, 8'h0F);
        w0 = we_cnt;
        send(CMD_EMIT, 5'd0, 4'd0, 3'd0, 7'd0, 8'd0);
        chk("wo_ovf_code", {30'd0, m_code}, 32'd2);
        chk("wo_ovf_no_write", we_cnt, w0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
